// File: rtl/ftb_update_sched.sv
// FTB update scheduler: queues commit-path updates and time-shares the
// single FTB port between BPU lookups and queued updates.
`ifndef XDEF
`define XDEF [63:0]
`endif

package ftb_pkg;
    typedef struct packed {
        logic        valid;
        logic [1:0]  br_type;
        logic [12:0] br_off;
        logic [31:0] target;
    } ftbInfo_t;
endpackage

module ftb_update_sched
    import ftb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_upd_vld,
    output logic                       o_upd_rdy,
    input  logic `XDEF                 i_upd_pc,
    input  ftbInfo_t                   i_upd_ftbInfo,
    input  logic                       i_lookup_req,
    output logic                       o_lookup_gnt,
    output logic                       o_ftb_lookup_req,
    output logic                       o_ftb_update_req,
    output logic `XDEF                 o_ftb_update_pc,
    output ftbInfo_t                   o_ftb_update_ftbInfo,
    input  logic                       i_ftb_update_finished,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state;
    logic `XDEF      pc_mem   [DEPTH];
    ftbInfo_t        info_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve;
    logic [1:0]      rst_sync;
    logic            rst_n;

    logic            nonempty;
    logic            full;
    logic            issue;
    logic            gnt;
    logic            push;
    logic            pop;

    // Async assert, two-flop synchronised release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_comb begin
        nonempty = (count != '0);
        full     = (count == CW'(DEPTH));
        issue    = (state == IDLE) && nonempty && !i_flush &&
                   (!i_lookup_req || starve == SW'(STARVE_LIMIT) || full);
        gnt      = (state == IDLE) && i_lookup_req && !issue;
        push     = i_upd_vld && !full && !i_flush;
        pop      = (state == WAIT) && i_ftb_update_finished;
    end

    assign o_upd_rdy            = !full;
    assign o_lookup_gnt         = gnt;
    assign o_ftb_lookup_req     = gnt;
    assign o_ftb_update_req     = issue;
    assign o_ftb_update_pc      = pc_mem[rd_ptr];
    assign o_ftb_update_ftbInfo = info_mem[rd_ptr];
    assign o_count              = count;
    assign o_busy               = (state == WAIT);

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= i_upd_pc;
            info_mem[wr_ptr] <= i_upd_ftbInfo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            starve <= '0;
        end else begin
            if (state == IDLE) begin
                if (issue) begin
                    state  <= WAIT;
                    starve <= '0;
                end else if (!nonempty) begin
                    starve <= '0;
                end else if (gnt && starve != SW'(STARVE_LIMIT)) begin
                    starve <= starve + SW'(1);
                end
            end else if (i_ftb_update_finished) begin
                state <= IDLE;
            end

            // A flush mid-update keeps only the in-flight head.
            if (i_flush) begin
                if (state == WAIT && !pop) begin
                    count  <= CW'(1);
                    wr_ptr <= rd_ptr + AW'(1);
                end else begin
                    count  <= '0;
                    rd_ptr <= wr_ptr;
                end
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_ftb_update_sched.sv
// Randomised and directed bench for ftb_update_sched against a
// queue-based reference model.
module tb_ftb_update_sched;
    import ftb_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIM   = 8;

    logic        clk;
    logic        rst;
    logic        i_flush;
    logic        i_upd_vld;
    logic        o_upd_rdy;
    logic [63:0] i_upd_pc;
    ftbInfo_t    i_upd_ftbInfo;
    logic        i_lookup_req;
    logic        o_lookup_gnt;
    logic        o_ftb_lookup_req;
    logic        o_ftb_update_req;
    logic [63:0] o_ftb_update_pc;
    ftbInfo_t    o_ftb_update_ftbInfo;
    logic        i_ftb_update_finished;
    logic [2:0]  o_count;
    logic        o_busy;

    ftb_update_sched #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_flush               (i_flush),
        .i_upd_vld             (i_upd_vld),
        .o_upd_rdy             (o_upd_rdy),
        .i_upd_pc              (i_upd_pc),
        .i_upd_ftbInfo         (i_upd_ftbInfo),
        .i_lookup_req          (i_lookup_req),
        .o_lookup_gnt          (o_lookup_gnt),
        .o_ftb_lookup_req      (o_ftb_lookup_req),
        .o_ftb_update_req      (o_ftb_update_req),
        .o_ftb_update_pc       (o_ftb_update_pc),
        .o_ftb_update_ftbInfo  (o_ftb_update_ftbInfo),
        .i_ftb_update_finished (i_ftb_update_finished),
        .o_count               (o_count),
        .o_busy                (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mq_pc  [$];
    ftbInfo_t    mq_inf [$];
    bit          m_busy;
    int          m_starve;
    int          n_chk;
    int          n_pass;

    bit          s_gnt;
    bit          s_req;
    bit          s_rdy;
    bit          s_busy;
    int          s_cnt;
    logic [63:0] s_pc;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic ftbInfo_t rnd_info();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return ftbInfo_t'(r[47:0]);
    endfunction

    task automatic step(input bit vld, input logic [63:0] pc, input bit lk,
                        input bit fl, input bit fin);
        int       n;
        bit       iss;
        bit       gnt;
        bit       acc;
        ftbInfo_t inf;
        inf                   = rnd_info();
        i_upd_vld             = vld;
        i_upd_pc              = pc;
        i_upd_ftbInfo         = inf;
        i_lookup_req          = lk;
        i_flush               = fl;
        i_ftb_update_finished = fin;
        #1;
        n   = mq_pc.size();
        iss = !m_busy && n > 0 && !fl &&
              (!lk || m_starve == LIM || n == DEPTH);
        gnt = !m_busy && lk && !iss;
        chk("upd_rdy", 64'(o_upd_rdy), 64'(n < DEPTH));
        chk("count", 64'(o_count), 64'(n));
        chk("busy", 64'(o_busy), 64'(m_busy));
        chk("lookup_gnt", 64'(o_lookup_gnt), 64'(gnt));
        chk("ftb_lookup_req", 64'(o_ftb_lookup_req), 64'(gnt));
        chk("update_req", 64'(o_ftb_update_req), 64'(iss));
        if (n > 0) begin
            chk("head_pc", o_ftb_update_pc, mq_pc[0]);
            chk("head_info", 64'(o_ftb_update_ftbInfo), 64'(mq_inf[0]));
        end
        s_gnt  = o_lookup_gnt;
        s_req  = o_ftb_update_req;
        s_rdy  = o_upd_rdy;
        s_busy = o_busy;
        s_cnt  = int'(o_count);
        s_pc   = o_ftb_update_pc;
        @(posedge clk);
        acc = vld && n < DEPTH && !fl;
        if (m_busy) begin
            if (fl) begin
                while (mq_pc.size() > 1) begin
                    void'(mq_pc.pop_back());
                    void'(mq_inf.pop_back());
                end
            end
            if (fin) begin
                void'(mq_pc.pop_front());
                void'(mq_inf.pop_front());
                m_busy = 0;
            end
        end else begin
            if (fl) begin
                mq_pc.delete();
                mq_inf.delete();
            end
            if (iss) begin
                m_busy   = 1;
                m_starve = 0;
            end else if (n == 0) m_starve = 0;
            else if (gnt && m_starve < LIM) m_starve++;
        end
        if (acc) begin
            mq_pc.push_back(pc);
            mq_inf.push_back(inf);
        end
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (mq_pc.size() != 0 || m_busy); k++)
            step(0, 64'h0, 0, 0, m_busy);
        chk("drain_count", 64'(o_count), 64'h0);
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, "_rdy"}, 64'(o_upd_rdy), 64'h1);
        chk({tag, "_count"}, 64'(o_count), 64'h0);
        chk({tag, "_busy"}, 64'(o_busy), 64'h0);
        chk({tag, "_gnt"}, 64'(o_lookup_gnt), 64'h0);
        chk({tag, "_lreq"}, 64'(o_ftb_lookup_req), 64'h0);
        chk({tag, "_ureq"}, 64'(o_ftb_update_req), 64'h0);
    endtask

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        m_busy   = 0;
        m_starve = 0;
        rst                   = 1'b0;
        i_flush               = 1'b0;
        i_upd_vld             = 1'b0;
        i_upd_pc              = 64'h0;
        i_upd_ftbInfo         = '0;
        i_lookup_req          = 1'b0;
        i_ftb_update_finished = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle_outs("reset");
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int c = 0; c < 3; c++) begin
            step(0, 64'h0, 1, 0, 0);
            chk("idle_gnt", 64'(s_gnt), 64'h1);
        end

        step(1, 64'h1000, 0, 0, 0);
        step(0, 64'h0, 0, 0, 0);
        chk("single_req", 64'(s_req), 64'h1);
        chk("single_pc", s_pc, 64'h1000);
        step(0, 64'h0, 0, 0, 1);
        step(0, 64'h0, 0, 0, 0);
        chk("single_cnt", 64'(s_cnt), 64'h0);

        for (int c = 0; c < 12; c++) begin
            step(c == 0, 64'h2000, 1, 0, m_busy);
            if (c >= 1 && c <= 8) chk("starve_gnt", 64'(s_gnt), 64'h1);
            if (c == 9) begin
                chk("starve_req", 64'(s_req), 64'h1);
                chk("starve_gnt9", 64'(s_gnt), 64'h0);
            end
            if (c == 10) chk("starve_wait", 64'(s_gnt), 64'h0);
            if (c == 11) chk("starve_gnt11", 64'(s_gnt), 64'h1);
        end

        for (int c = 0; c < 7; c++) begin
            step(c < 5, 64'h3000 + 64'(c), 1, 0, m_busy);
            if (c == 4) begin
                chk("full_rdy", 64'(s_rdy), 64'h0);
                chk("full_cnt", 64'(s_cnt), 64'h4);
                chk("full_req", 64'(s_req), 64'h1);
            end
            if (c == 6) chk("full_rdy_after", 64'(s_rdy), 64'h1);
        end
        drain();

        for (int c = 0; c < 3; c++) step(1, 64'h4000 + 64'(c), 1, 0, 0);
        step(0, 64'h0, 0, 0, 0);
        chk("flush_issue", 64'(s_req), 64'h1);
        step(1, 64'h4fff, 0, 1, 0);
        step(0, 64'h0, 0, 0, 0);
        chk("flush_cnt1", 64'(s_cnt), 64'h1);
        chk("flush_busy", 64'(s_busy), 64'h1);
        step(0, 64'h0, 0, 0, 1);
        step(0, 64'h0, 0, 0, 0);
        chk("flush_cnt0", 64'(s_cnt), 64'h0);
        chk("flush_noreq", 64'(s_req), 64'h0);
        for (int k = 0; k < 6; k++) begin
            step(1, 64'h5000 + 64'(k), 0, 0, 0);
            step(0, 64'h0, 0, 0, 0);
            chk("wrap_pc", s_pc, 64'h5000 + 64'(k));
            drain();
        end

        step(1, 64'h6000, 0, 0, 0);
        step(1, 64'h6001, 0, 0, 0);
        step(1, 64'h6002, 0, 0, 0);
        step(0, 64'h0, 0, 0, 0);
        chk("pre_rst_busy", 64'(s_busy), 64'h1);
        i_upd_vld = 1'b0;
        i_flush   = 1'b0;
        #2 rst = 1'b0;
        #1;
        idle_outs("async_rst");
        i_ftb_update_finished = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        mq_pc.delete();
        mq_inf.delete();
        m_busy   = 0;
        m_starve = 0;
        repeat (3) @(posedge clk);
        #1;
        step(0, 64'h0, 0, 0, 1);
        step(0, 64'h0, 0, 0, 1);
        chk("late_fin_cnt", 64'(s_cnt), 64'h0);

        for (int c = 0; c < 400; c++) begin
            bit fin;
            fin = m_busy ? ($urandom % 3 != 0) : ($urandom % 8 == 0);
            step($urandom % 2 == 1, {$urandom, $urandom},
                 $urandom % 3 != 0, $urandom % 23 == 0, fin);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
